// File: rtl/pinmux_pkg.sv
// Shared types for the pad input filter.
// Holds the per-pad filter configuration struct and its default width.
package pinmux_pkg;

  localparam int unsigned FiltCntWDef = 4;

  typedef struct packed {
    logic                   filter_en;
    logic [FiltCntWDef-1:0] thresh;
  } pad_filt_cfg_t;

  // A disabled filter behaves as threshold zero.
  function automatic logic [FiltCntWDef-1:0] eff_thresh(
    input pad_filt_cfg_t cfg
  );
    return cfg.filter_en ? cfg.thresh : '0;
  endfunction

endpackage

// File: rtl/pinmux_pad_in_filter_chan.sv
// One pad input channel: synchronizer, glitch filter, edge detect.
// Edge detect registers exist only with PINMUX_PAD_IN_EDGE_DET_EN.
module pinmux_pad_in_filter_chan
  import pinmux_pkg::*;
#(
  parameter int unsigned FiltCntW = FiltCntWDef
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pad_i,
  input  logic          oe_i,
  input  pad_filt_cfg_t cfg_i,
  output logic          in_o,
  output logic          rise_o,
  output logic          fall_o
);

  logic [1:0]          sync_q;
  logic                sync;
  logic [FiltCntW-1:0] cnt_q, cnt_d;
  logic [FiltCntW-1:0] thr;
  logic                out_q, out_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pad_i};
    end
  end

  assign sync = sync_q[1];
  assign thr  = FiltCntW'(eff_thresh(cfg_i));

  // oe wins over everything so a driven pad never disturbs the output.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (oe_i) begin
      cnt_d = '0;
    end else if (sync == out_q) begin
      cnt_d = '0;
    end else if (cnt_q >= thr) begin
      out_d = sync;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign in_o = out_q;

`ifdef PINMUX_PAD_IN_EDGE_DET_EN
  logic rise_q, fall_q;

  // Computed from out_d so the pulse lines up with the new in_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/pinmux_pad_in_filter.sv
// Pad input filter bank: one independent channel per pad.
// Edge events are built only when PINMUX_PAD_IN_EDGE_DET_EN is defined.
module pinmux_pad_in_filter
  import pinmux_pkg::*;
#(
  parameter int unsigned NumPads  = 4,
  parameter int unsigned FiltCntW = FiltCntWDef
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic          [NumPads-1:0] pad_in_i,
  input  logic          [NumPads-1:0] pad_oe_i,
  input  pad_filt_cfg_t [NumPads-1:0] filt_cfg_i,
  output logic          [NumPads-1:0] in_o,
  output logic          [NumPads-1:0] rise_o,
  output logic          [NumPads-1:0] fall_o
);

  for (genvar g = 0; g < NumPads; g++) begin : g_chan
    pinmux_pad_in_filter_chan #(
      .FiltCntW(FiltCntW)
    ) u_chan (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .pad_i (pad_in_i[g]),
      .oe_i  (pad_oe_i[g]),
      .cfg_i (filt_cfg_i[g]),
      .in_o  (in_o[g]),
      .rise_o(rise_o[g]),
      .fall_o(fall_o[g])
    );
  end

endmodule

// File: tb/tb_pinmux_pad_in_filter.sv
// Directed plus random bench for pinmux_pad_in_filter.
// Reference model tracks per-pad mismatch run lengths at cycle level.
module tb_pinmux_pad_in_filter;
  import pinmux_pkg::*;

  localparam int NP = 4;
`ifdef PINMUX_PAD_IN_EDGE_DET_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic          [NP-1:0] pad_in;
  logic          [NP-1:0] pad_oe;
  pad_filt_cfg_t [NP-1:0] cfg;
  logic          [NP-1:0] in_o, rise_o, fall_o;

  int n_chk = 0;
  int n_err = 0;

  logic [NP-1:0] hist[$];
  logic [NP-1:0] mout, mrise, mfall;
  int            age[NP];

  pinmux_pad_in_filter #(
    .NumPads (NP),
    .FiltCntW(4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pad_in_i  (pad_in),
    .pad_oe_i  (pad_oe),
    .filt_cfg_i(cfg),
    .in_o      (in_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    mout  = '0;
    mrise = '0;
    mfall = '0;
    for (int i = 0; i < NP; i++) age[i] = 0;
  endtask

  // A pad value is seen by the filter two edges after it is sampled.
  // The output flips once the mismatch has lasted T+1 edges.
  task automatic model_edge();
    logic [NP-1:0] s;
    logic          nv;
    int            t;
    if (rst) begin
      model_reset();
      return;
    end
    s = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    for (int i = 0; i < NP; i++) begin
      t  = cfg[i].filter_en ? int'(cfg[i].thresh) : 0;
      nv = mout[i];
      if (pad_oe[i] || s[i] == mout[i]) begin
        age[i] = 0;
      end else if (age[i] >= t) begin
        nv     = s[i];
        age[i] = 0;
      end else begin
        age[i] = age[i] + 1;
      end
      mrise[i] = nv & ~mout[i];
      mfall[i] = ~nv & mout[i];
      mout[i]  = nv;
    end
    hist.push_back(pad_in);
    if (hist.size() > 2) void'(hist.pop_front());
  endtask

  task automatic chk_model();
    chk("in_model", 32'(in_o), 32'(mout));
    chk("rise_model", 32'(rise_o), EDGE ? 32'(mrise) : 32'd0);
    chk("fall_model", 32'(fall_o), EDGE ? 32'(mfall) : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  initial begin
    rst    = 1'b1;
    pad_in = '0;
    pad_oe = '0;
    cfg    = '0;
    model_reset();
    #1;
    chk("reset_in", 32'(in_o), 32'd0);
    chk("reset_rise", 32'(rise_o), 32'd0);
    chk("reset_fall", 32'(fall_o), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Filter off: a step reaches in_o after exactly three edges.
    for (int c = 0; c < 10; c++) step();
    pad_in[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("p0_in", 32'(in_o[0]), 32'(c >= 3));
      chk("p0_rise", 32'(rise_o[0]), 32'(EDGE && c == 3));
    end

    // Glitch shorter than the threshold is swallowed.
    cfg[1] = '{filter_en: 1'b1, thresh: 4'd5};
    pad_in[1] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      if (c == 5) pad_in[1] = 1'b0;
      step();
      chk("p1_glitch_in", 32'(in_o[1]), 32'd0);
      chk("p1_glitch_ev", 32'({rise_o[1], fall_o[1]}), 32'd0);
    end

    // Stable change with threshold 5 needs 2+5+1 edges.
    pad_in[1] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("p1_in", 32'(in_o[1]), 32'(c >= 8));
      chk("p1_rise", 32'(rise_o[1]), 32'(EDGE && c == 8));
    end

    // Output-enabled pad ignores toggling input.
    pad_oe[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      pad_in[2] = ((c / 2) % 2 == 0);
      step();
      chk("p2_oe_in", 32'(in_o[2]), 32'd0);
      chk("p2_oe_ev", 32'({rise_o[2], fall_o[2]}), 32'd0);
    end
    pad_oe[2] = 1'b0;
    pad_in[2] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("p2_release", 32'(in_o[2]), 32'(c >= 3));
    end

    // Reset mid-count clears everything without waiting for a clock.
    cfg[3] = '{filter_en: 1'b1, thresh: 4'd15};
    pad_in[3] = 1'b1;
    for (int c = 0; c < 10; c++) step();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_in", 32'(in_o), 32'd0);
    chk("rst_async_ev", 32'({rise_o, fall_o}), 32'd0);
    step();
    rst = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      step();
      chk("p3_after_rst", 32'(in_o[3]), 32'(c >= 18));
      chk("p3_rise", 32'(rise_o[3]), 32'(EDGE && c == 18));
    end

    // Random traffic with threshold changes, oe and occasional reset.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 5) == 0) pad_in[i] = ~pad_in[i];
        if ($urandom_range(0, 19) == 0) pad_oe[i] = ~pad_oe[i];
        if ($urandom_range(0, 29) == 0) begin
          cfg[i].filter_en = 1'($urandom_range(0, 1));
          cfg[i].thresh    = 4'($urandom_range(0, 6));
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin
        model_reset();
        #1;
        chk("rnd_rst", 32'({in_o, rise_o, fall_o}), 32'd0);
      end
      step();
      rst = 1'b0;
      chk("rnd_excl", 32'(rise_o & fall_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
